regfile_mp: RTL and testbench

- Parametrised successor of the renaming register file in the execute stage.
- Holds the architectural value and pending ROB tag per register. Serves NRD decode read ports and one rename port per cycle, and accepts NWB in-order ROB commits per cycle.
- Adds hard x0 protection, dual-commit write ordering, and multi-port commit/rename bypass.

---
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: renaming register file with NRD read ports, x0 protection and multi-port commit/rename bypass.
module regfile_mp #(
  parameter int REG_BIT = 5,
  parameter int ROB_BIT = 4,
  parameter int XLEN = 32,
  parameter int NRD = 2,
  parameter int NWB = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   reg_en,
  input  logic                   reg_st,
  input  logic                   reg_rb,
  input  logic [NRD*REG_BIT-1:0] id_rs,
  output logic [NRD*ROB_BIT-1:0] id_src,
  output logic [NRD*XLEN-1:0]    id_val,
  input  logic                   id_rn_ena,
  input  logic [REG_BIT-1:0]     id_rn_rd,
  input  logic [ROB_BIT-1:0]     id_rn_idx,
  input  logic [NWB-1:0]         rob_wr_ena,
  input  logic [NWB*REG_BIT-1:0] rob_wr_rd,
  input  logic [NWB*XLEN-1:0]    rob_wr_val,
  input  logic [NWB*ROB_BIT-1:0] rob_wr_idx
);
  localparam int REG_SIZE = 1 << REG_BIT;
  logic [ROB_BIT-1:0] src [REG_SIZE];
  logic [XLEN-1:0] val [REG_SIZE];
  logic [REG_BIT-1:0] wr_rd [NWB];
  logic [ROB_BIT-1:0] wr_idx [NWB];
  logic [XLEN-1:0] wr_val [NWB];
  for (genvar j = 0; j < NWB; j++) begin : g_wb
    assign wr_rd[j] = rob_wr_rd[j*REG_BIT +: REG_BIT];
    assign wr_idx[j] = rob_wr_idx[j*ROB_BIT +: ROB_BIT];
    assign wr_val[j] = rob_wr_val[j*XLEN +: XLEN];
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [REG_BIT-1:0] r;
    logic hit;
    logic [XLEN-1:0] v;
    assign r = id_rs[k*REG_BIT +: REG_BIT];
    always_comb begin
      hit = 1'b0;
      v = val[r];
      for (int j = 0; j < NWB; j++)
        if (rob_wr_ena[j] && wr_rd[j] == r && wr_idx[j] == src[r]) begin
          hit = 1'b1;
          v = wr_val[j];
        end
    end
    assign id_src[k*ROB_BIT +: ROB_BIT] = r == '0 ? '0 : (id_rn_ena && id_rn_rd == r) ? id_rn_idx : hit ? '0 : src[r];
    assign id_val[k*XLEN +: XLEN] = r == '0 ? '0 : v;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < REG_SIZE; i++) begin
        src[i] <= '0;
        val[i] <= '0;
      end
    end else if (reg_rb || (rdy && reg_en && !reg_st)) begin
      for (int j = 0; j < NWB; j++)
        if (rob_wr_ena[j] && wr_rd[j] != '0) begin
          val[wr_rd[j]] <= wr_val[j];
          if (!reg_rb && wr_idx[j] == src[wr_rd[j]]) src[wr_rd[j]] <= '0;
        end
      if (reg_rb) begin
        for (int i = 0; i < REG_SIZE; i++) src[i] <= '0;
      end else if (id_rn_ena && id_rn_rd != '0) src[id_rn_rd] <= id_rn_idx;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus against a behavioural register-file model, checked every cycle plus literal expectations.
module tb_regfile_mp;
  localparam int RB = 5, TB = 4, XL = 32, NRD = 2, NWB = 2;
  logic clk = 0, rst, rdy, reg_en, reg_st, reg_rb;
  logic [NRD*RB-1:0] id_rs;
  logic [NRD*TB-1:0] id_src;
  logic [NRD*XL-1:0] id_val;
  logic id_rn_ena;
  logic [RB-1:0] id_rn_rd;
  logic [TB-1:0] id_rn_idx;
  logic [NWB-1:0] rob_wr_ena;
  logic [NWB*RB-1:0] rob_wr_rd;
  logic [NWB*XL-1:0] rob_wr_val;
  logic [NWB*TB-1:0] rob_wr_idx;
  int pass = 0, total = 0;
  logic [TB-1:0] msrc [32];
  logic [XL-1:0] mval [32];

  regfile_mp #(.REG_BIT(RB), .ROB_BIT(TB), .XLEN(XL), .NRD(NRD), .NWB(NWB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .reg_en(reg_en), .reg_st(reg_st), .reg_rb(reg_rb),
    .id_rs(id_rs), .id_src(id_src), .id_val(id_val),
    .id_rn_ena(id_rn_ena), .id_rn_rd(id_rn_rd), .id_rn_idx(id_rn_idx),
    .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd), .rob_wr_val(rob_wr_val), .rob_wr_idx(rob_wr_idx));

  always #5 clk = ~clk;

  function automatic logic [RB-1:0] wrd(int j); return rob_wr_rd[j*RB +: RB]; endfunction
  function automatic logic [TB-1:0] widx(int j); return rob_wr_idx[j*TB +: TB]; endfunction
  function automatic logic [XL-1:0] wval(int j); return rob_wr_val[j*XL +: XL]; endfunction

  // Architectural model: a commit always lands its value, frees the register only if it is still the pending producer.
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        msrc[i] <= 0;
        mval[i] <= 0;
      end
    end else if (reg_rb || (rdy && reg_en && !reg_st)) begin
      for (int j = 0; j < NWB; j++)
        if (rob_wr_ena[j] && wrd(j) != 0) begin
          mval[wrd(j)] <= wval(j);
          if (!reg_rb && widx(j) == msrc[wrd(j)]) msrc[wrd(j)] <= 0;
        end
      if (reg_rb) begin
        for (int i = 0; i < 32; i++) msrc[i] <= 0;
      end else if (id_rn_ena && id_rn_rd != 0) msrc[id_rn_rd] <= id_rn_idx;
    end

  task automatic expect_rd(input logic [RB-1:0] r, output logic [TB-1:0] es, output logic [XL-1:0] ev);
    logic hit = 0;
    ev = mval[r];
    for (int j = 0; j < NWB; j++)
      if (rob_wr_ena[j] && wrd(j) == r && widx(j) == msrc[r]) begin
        hit = 1;
        ev = wval(j);
      end
    es = (id_rn_ena && id_rn_rd == r) ? id_rn_idx : hit ? 0 : msrc[r];
    if (r == 0) begin
      es = 0;
      ev = 0;
    end
  endtask

  task automatic chk(input string n, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got %0h expected %0h", n, got, exp);
  endtask

  always @(negedge clk) begin
    logic [TB-1:0] es;
    logic [XL-1:0] ev;
    for (int k = 0; k < NRD; k++) begin
      expect_rd(id_rs[k*RB +: RB], es, ev);
      chk($sformatf("model_src%0d@%0t", k, $time), XL'(id_src[k*TB +: TB]), XL'(es));
      chk($sformatf("model_val%0d@%0t", k, $time), id_val[k*XL +: XL], ev);
    end
  end

  task automatic tick; @(posedge clk); #2; endtask
  task automatic clr;
    rdy = 1; reg_en = 1; reg_st = 0; reg_rb = 0;
    id_rn_ena = 0; id_rn_rd = 0; id_rn_idx = 0;
    rob_wr_ena = 0; rob_wr_rd = 0; rob_wr_val = 0; rob_wr_idx = 0;
  endtask
  task automatic rs(input int k, input logic [RB-1:0] r); id_rs[k*RB +: RB] = r; endtask
  task automatic rn(input logic [RB-1:0] rd, input logic [TB-1:0] idx);
    id_rn_ena = 1; id_rn_rd = rd; id_rn_idx = idx;
  endtask
  task automatic wb(input int j, input logic [RB-1:0] rd, input logic [TB-1:0] idx, input logic [XL-1:0] v);
    rob_wr_ena[j] = 1; rob_wr_rd[j*RB +: RB] = rd; rob_wr_idx[j*TB +: TB] = idx; rob_wr_val[j*XL +: XL] = v;
  endtask
  task automatic lit(input string n, input int k, input logic [TB-1:0] es, input logic [XL-1:0] ev);
    chk({n, "_src"}, XL'(id_src[k*TB +: TB]), XL'(es));
    chk({n, "_val"}, id_val[k*XL +: XL], ev);
  endtask

  initial begin
    rst = 1; id_rs = 0; clr;
    tick; tick;
    rs(0, 5); rs(1, 1);
    #1 lit("reset", 0, 0, 0);
    rst = 0;
    // Reset mid-operation: build src[5]=3 and val[5]=0x11 via a stale commit
    rn(5, 3); tick; clr;
    wb(0, 5, 9, 'h11); tick; clr;
    #1 lit("pre_async", 0, 3, 'h11);
    rst = 1;
    #1 lit("async_rst", 0, 0, 0);
    rst = 0;
    // Rename + read same cycle
    tick; clr;
    rn(7, 4); rs(0, 7); rs(1, 5);
    #1 chk("rn_bypass", XL'(id_src[TB-1:0]), 4);
    tick; clr;
    #1 lit("rn_state", 0, 4, 0);
    // Commit bypass
    wb(0, 7, 4, 'hDEAD);
    #1 lit("wb_bypass", 0, 0, 'hDEAD);
    tick; clr;
    #1 lit("wb_state", 0, 0, 'hDEAD);
    // Dual commit to the same register
    rn(9, 6); tick; clr;
    wb(0, 9, 5, 'hA); wb(1, 9, 6, 'hB); rs(0, 9);
    #1 lit("dual_bypass", 0, 0, 'hB);
    tick; clr;
    #1 lit("dual_state", 0, 0, 'hB);
    rn(9, 6); tick; clr;
    wb(0, 9, 5, 'hA); wb(1, 9, 6, 'hC); rn(9, 2);
    #1 lit("dual_rn_bypass", 0, 2, 'hC);
    tick; clr;
    #1 lit("dual_rn_state", 0, 2, 'hC);
    // x0 protection
    rn(0, 3); wb(0, 0, 1, 'hFF); wb(1, 0, 0, 'hEE); rs(0, 0); rs(1, 0);
    #1 lit("x0_bypass", 1, 0, 0);
    tick; clr;
    #1 lit("x0_state", 0, 0, 0);
    // Fill every src, then roll back under rdy=0 with a commit
    for (int r = 1; r < 32; r++) begin
      rn(RB'(r), TB'(r % 15 + 1)); rs(0, RB'(r)); rs(1, RB'(r - 1));
      tick; clr;
    end
    rs(0, 20); rs(1, 3);
    #1 lit("filled", 0, 6, 0);
    reg_rb = 1; rdy = 0; wb(0, 3, 7, 'h55); rn(4, 9);
    tick; clr;
    #1 lit("rb_r3", 1, 0, 'h55);
    lit("rb_r20", 0, 0, 0);
    rs(0, 4); rs(1, 7);
    #1 lit("rb_r4", 0, 0, 0);
    lit("rb_r7", 1, 0, 'hDEAD);
    // Each stall source freezes state while reads stay live
    rn(12, 5); tick; clr;
    for (int s = 0; s < 3; s++) begin
      rdy = s != 0; reg_en = s != 1; reg_st = s == 2;
      rn(12, 9); wb(0, 12, 5, 'h77); rs(0, 12);
      #1 lit("stall_bypass", 0, 9, 'h77);
      tick; clr;
      #1 lit("stall_state", 0, 5, 0);
    end
    tick; tick;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
